// File: rtl/axi_drain_gate.sv
// AXI quiesce gate: caps outstanding AW/AR transactions, drains them on isolate
// request and then blocks every channel until isolation is released.
package axi_drain_gate_pkg;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned IdW   = 4;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
  } ax_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    r_t   r;
    logic r_valid;
  } resp_t;
endpackage

module axi_drain_gate #(
  parameter int unsigned MaxTxns = 8,
  parameter type axi_req_t  = axi_drain_gate_pkg::req_t,
  parameter type axi_resp_t = axi_drain_gate_pkg::resp_t,
  localparam int unsigned CW = $clog2(MaxTxns + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          isolate_i,
  output logic          isolated_o,
  input  axi_req_t      slv_req_i,
  output axi_resp_t     slv_resp_o,
  output axi_req_t      mst_req_o,
  input  axi_resp_t     mst_resp_i,
  output logic [CW-1:0] pending_wr_o,
  output logic [CW-1:0] pending_rd_o
);

  typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wr_cnt, wr_cnt_next;
  logic [CW-1:0] rd_cnt, rd_cnt_next;
  logic          aw_hold, aw_hold_next;
  logic          ar_hold, ar_hold_next;
  logic          aw_open, ar_open, blocked;
  logic          aw_hs, ar_hs, b_hs, r_last_hs;

  // A hold flag keeps an already-presented valid alive whatever the state or limit.
  always_comb begin
    aw_open = aw_hold || ((state == NORMAL) && (wr_cnt < CW'(MaxTxns)));
    ar_open = ar_hold || ((state == NORMAL) && (rd_cnt < CW'(MaxTxns)));
    blocked = (state == ISOLATED);
  end

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
    if (blocked) begin
      mst_req_o.w_valid  = 1'b0;
      slv_resp_o.w_ready = 1'b0;
      slv_resp_o.b_valid = 1'b0;
      mst_req_o.b_ready  = 1'b0;
      slv_resp_o.r_valid = 1'b0;
      mst_req_o.r_ready  = 1'b0;
    end
  end

  always_comb begin
    aw_hs     = slv_req_i.aw_valid & aw_open & mst_resp_i.aw_ready;
    ar_hs     = slv_req_i.ar_valid & ar_open & mst_resp_i.ar_ready;
    b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready & ~blocked;
    r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last & ~blocked;
  end

  // Counters move only on downstream handshakes; an underflow attempt holds.
  always_comb begin
    wr_cnt_next = wr_cnt;
    rd_cnt_next = rd_cnt;
    if (aw_hs && !b_hs) begin
      wr_cnt_next = wr_cnt + CW'(1);
    end else if (!aw_hs && b_hs && (wr_cnt != '0)) begin
      wr_cnt_next = wr_cnt - CW'(1);
    end
    if (ar_hs && !r_last_hs) begin
      rd_cnt_next = rd_cnt + CW'(1);
    end else if (!ar_hs && r_last_hs && (rd_cnt != '0)) begin
      rd_cnt_next = rd_cnt - CW'(1);
    end
    aw_hold_next = slv_req_i.aw_valid & aw_open & ~mst_resp_i.aw_ready;
    ar_hold_next = slv_req_i.ar_valid & ar_open & ~mst_resp_i.ar_ready;
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: begin
        if (isolate_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (!isolate_i) begin
          state_next = NORMAL;
        end else if ((wr_cnt_next == '0) && (rd_cnt_next == '0) &&
                     !aw_hold_next && !ar_hold_next) begin
          state_next = ISOLATED;
        end
      end
      ISOLATED: begin
        if (!isolate_i) state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= NORMAL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      aw_hold    <= 1'b0;
      ar_hold    <= 1'b0;
      isolated_o <= 1'b0;
    end else begin
      state      <= state_next;
      wr_cnt     <= wr_cnt_next;
      rd_cnt     <= rd_cnt_next;
      aw_hold    <= aw_hold_next;
      ar_hold    <= ar_hold_next;
      isolated_o <= (state_next == ISOLATED);
    end
  end

  assign pending_wr_o = wr_cnt;
  assign pending_rd_o = rd_cnt;

  a_no_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(b_hs && !aw_hs && (wr_cnt == '0)));
  a_no_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_last_hs && !ar_hs && (rd_cnt == '0)));

endmodule

// File: tb/tb_axi_drain_gate.sv
// Directed self-checking bench for axi_drain_gate: default instance plus a
// MaxTxns=2 instance for the outstanding-limit scenario.
module tb_axi_drain_gate;
  import axi_drain_gate_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic isolate_i;
  logic isolated;
  req_t  slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  logic [3:0] pend_wr, pend_rd;

  logic isolate2, isolated2;
  req_t  slv_req2, mst_req2;
  resp_t slv_resp2, mst_resp2;
  logic [1:0] pend_wr2, pend_rd2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  axi_drain_gate dut (
    .clk_i(clk_i), .rst_i(rst_i), .isolate_i(isolate_i), .isolated_o(isolated),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp), .mst_req_o(mst_req),
    .mst_resp_i(mst_resp), .pending_wr_o(pend_wr), .pending_rd_o(pend_rd)
  );

  axi_drain_gate #(.MaxTxns(2)) dut_lim (
    .clk_i(clk_i), .rst_i(rst_i), .isolate_i(isolate2), .isolated_o(isolated2),
    .slv_req_i(slv_req2), .slv_resp_o(slv_resp2), .mst_req_o(mst_req2),
    .mst_resp_i(mst_resp2), .pending_wr_o(pend_wr2), .pending_rd_o(pend_rd2)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    isolate_i = 1'b0;
    isolate2 = 1'b0;
    slv_req = '0; mst_resp = '0; slv_req2 = '0; mst_resp2 = '0;
    #12;
    total_cnt++;
    if ({isolated, pend_wr, pend_rd} !== 9'd0) $display("FAIL reset_state: got %b want 0", {isolated, pend_wr, pend_rd});
    else pass_cnt++;
    total_cnt++;
    if ({isolated2, pend_wr2, pend_rd2} !== 5'd0) $display("FAIL reset_state_lim: got %b want 0", {isolated2, pend_wr2, pend_rd2});
    else pass_cnt++;
    slv_req.aw_valid = 1'b1;
    #1;
    total_cnt++;
    if (mst_req.aw_valid !== 1'b1) $display("FAIL reset_gate_open: aw_valid got %b want 1", mst_req.aw_valid);
    else pass_cnt++;
    slv_req.aw_valid = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
    slv_req.aw.len = 8'd3;
    tick(); tick();
    slv_req.ar_valid = 1'b0;
    tick();
    slv_req.aw_valid = 1'b0;
    total_cnt++;
    if (pend_wr !== 4'd3) $display("FAIL b2b_peak_wr: got %0d want 3", pend_wr);
    else pass_cnt++;
    total_cnt++;
    if (pend_rd !== 4'd2) $display("FAIL b2b_peak_rd: got %0d want 2", pend_rd);
    else pass_cnt++;
    slv_req.w_valid = 1'b1;
    #1;
    total_cnt++;
    if ({mst_req.w_valid, slv_resp.w_ready} !== 2'b11) $display("FAIL b2b_w_pass: got %b want 11", {mst_req.w_valid, slv_resp.w_ready});
    else pass_cnt++;
    for (int i = 0; i < 12; i++) tick();
    slv_req.w_valid = 1'b0;
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    #1;
    total_cnt++;
    if (slv_resp.b_valid !== 1'b1) $display("FAIL b2b_b_pass: got %b want 1", slv_resp.b_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pend_wr !== 4'd2) $display("FAIL b2b_wr_after_b: got %0d want 2", pend_wr);
    else pass_cnt++;
    tick(); tick();
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b1; slv_req.r_ready = 1'b1; mst_resp.r.last = 1'b0;
    tick();
    total_cnt++;
    if (pend_rd !== 4'd2) $display("FAIL b2b_rd_nonlast: got %0d want 2", pend_rd);
    else pass_cnt++;
    mst_resp.r.last = 1'b1; tick();
    mst_resp.r.last = 1'b0; tick();
    mst_resp.r.last = 1'b1; tick();
    mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
    total_cnt++;
    if ({pend_wr, pend_rd} !== 8'd0) $display("FAIL b2b_drained: got wr=%0d rd=%0d want 0 0", pend_wr, pend_rd);
    else pass_cnt++;
    total_cnt++;
    if (isolated !== 1'b0) $display("FAIL b2b_not_isolated: got %b want 0", isolated);
    else pass_cnt++;
  endtask

  task automatic test_limit();
    mst_resp2.aw_ready = 1'b1; slv_req2.aw_valid = 1'b1;
    tick(); tick();
    total_cnt++;
    if (pend_wr2 !== 2'd2) $display("FAIL lim_count: got %0d want 2", pend_wr2);
    else pass_cnt++;
    total_cnt++;
    if ({slv_resp2.aw_ready, mst_req2.aw_valid} !== 2'b00) $display("FAIL lim_closed: got %b want 00", {slv_resp2.aw_ready, mst_req2.aw_valid});
    else pass_cnt++;
    mst_resp2.b_valid = 1'b1; slv_req2.b_ready = 1'b1;
    #1;
    total_cnt++;
    if (mst_req2.aw_valid !== 1'b0) $display("FAIL lim_closed_during_b: got %b want 0", mst_req2.aw_valid);
    else pass_cnt++;
    tick();
    mst_resp2.b_valid = 1'b0;
    #1;
    total_cnt++;
    if ({slv_resp2.aw_ready, mst_req2.aw_valid, pend_wr2} !== 4'b1101) $display("FAIL lim_reopen: got %b want 1101", {slv_resp2.aw_ready, mst_req2.aw_valid, pend_wr2});
    else pass_cnt++;
    tick();
    slv_req2.aw_valid = 1'b0; mst_resp2.b_valid = 1'b1;
    tick(); tick();
    mst_resp2.b_valid = 1'b0;
    total_cnt++;
    if (pend_wr2 !== 2'd0) $display("FAIL lim_drained: got %0d want 0", pend_wr2);
    else pass_cnt++;
  endtask

  task automatic test_drain_read();
    slv_req.ar_valid = 1'b1;
    tick(); tick();
    slv_req.ar_valid = 1'b0; isolate_i = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    #1;
    total_cnt++;
    if ({mst_req.ar_valid, slv_resp.ar_ready} !== 2'b00) $display("FAIL drain_ar_blocked: got %b want 00", {mst_req.ar_valid, slv_resp.ar_ready});
    else pass_cnt++;
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
    tick();
    total_cnt++;
    if ({isolated, pend_rd} !== 5'b0_0001) $display("FAIL drain_first_last: got iso=%b rd=%0d want 0 1", isolated, pend_rd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({isolated, pend_rd} !== 5'b1_0000) $display("FAIL drain_isolated_rise: got iso=%b rd=%0d want 1 0", isolated, pend_rd);
    else pass_cnt++;
    total_cnt++;
    if ({slv_resp.r_valid, mst_req.r_ready} !== 2'b00) $display("FAIL drain_r_blocked: got %b want 00", {slv_resp.r_valid, mst_req.r_ready});
    else pass_cnt++;
    mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
    slv_req.ar_valid = 1'b0; isolate_i = 1'b0;
    tick();
    total_cnt++;
    if (isolated !== 1'b0) $display("FAIL drain_release: got %b want 0", isolated);
    else pass_cnt++;
  endtask

  task automatic test_stalled_aw();
    mst_resp.aw_ready = 1'b0; slv_req.aw_valid = 1'b1;
    tick();
    isolate_i = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if ({mst_req.aw_valid, isolated} !== 2'b10) $display("FAIL stall_aw_held: got %b want 10", {mst_req.aw_valid, isolated});
    else pass_cnt++;
    mst_resp.aw_ready = 1'b1;
    #1;
    total_cnt++;
    if (slv_resp.aw_ready !== 1'b1) $display("FAIL stall_aw_ready: got %b want 1", slv_resp.aw_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mst_req.aw_valid, isolated, pend_wr} !== 6'b00_0001) $display("FAIL stall_after_hs: got %b want 000001", {mst_req.aw_valid, isolated, pend_wr});
    else pass_cnt++;
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    total_cnt++;
    if ({isolated, pend_wr} !== 5'b1_0000) $display("FAIL stall_isolated: got iso=%b wr=%0d want 1 0", isolated, pend_wr);
    else pass_cnt++;
  endtask

  task automatic test_isolated();
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; slv_req.w_valid = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total_cnt++;
      if ({mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid,
           slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready} !== 6'd0)
        $display("FAIL iso_blocked cycle %0d: got %b want 000000", i,
                 {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid,
                  slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({slv_resp.b_valid, slv_resp.r_valid, mst_req.b_ready, mst_req.r_ready, pend_wr, pend_rd} !== 12'd0)
      $display("FAIL iso_resp_blocked: got %b want 0", {slv_resp.b_valid, slv_resp.r_valid, mst_req.b_ready, mst_req.r_ready, pend_wr, pend_rd});
    else pass_cnt++;
    mst_resp.b_valid = 1'b0; mst_resp.r_valid = 1'b0;
    isolate_i = 1'b0;
    tick();
    total_cnt++;
    if ({isolated, mst_req.aw_valid} !== 2'b01) $display("FAIL iso_exit_forward: got %b want 01", {isolated, mst_req.aw_valid});
    else pass_cnt++;
    slv_req.ar_valid = 1'b0; slv_req.w_valid = 1'b0;
    tick();
    slv_req.aw_valid = 1'b0;
    total_cnt++;
    if (pend_wr !== 4'd1) $display("FAIL iso_exit_count: got %0d want 1", pend_wr);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous_and_reset();
    slv_req.aw_valid = 1'b1; mst_resp.b_valid = 1'b1;
    tick();
    total_cnt++;
    if (pend_wr !== 4'd1) $display("FAIL simul_aw_b: got %0d want 1", pend_wr);
    else pass_cnt++;
    mst_resp.b_valid = 1'b0;
    tick();
    slv_req.aw_valid = 1'b0; isolate_i = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1;
    #1;
    total_cnt++;
    if ({mst_req.aw_valid, pend_wr} !== 5'b0_0010) $display("FAIL pre_reset_drain: got %b want 00010", {mst_req.aw_valid, pend_wr});
    else pass_cnt++;
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({isolated, pend_wr, pend_rd, mst_req.aw_valid} !== 10'b0_0000_0000_1)
      $display("FAIL async_reset: got iso=%b wr=%0d rd=%0d aw_valid=%b want 0 0 0 1", isolated, pend_wr, pend_rd, mst_req.aw_valid);
    else pass_cnt++;
    slv_req.aw_valid = 1'b0; isolate_i = 1'b0;
    #1;
    rst_i = 1'b0;
    tick();
    total_cnt++;
    if ({isolated, pend_wr} !== 5'd0) $display("FAIL post_reset: got iso=%b wr=%0d want 0 0", isolated, pend_wr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_limit();
    test_drain_read();
    test_stalled_aw();
    test_isolated();
    test_simultaneous_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
